// File: rtl/seg7_pkg.sv
// seg7_pkg: shared scan state encodings and display constants
package seg7_pkg;
    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_BLANK = 2'd1,
        SCAN_SHOW  = 2'd2
    } scan_state_t;
    localparam logic [3:0] ANODE_OFF = 4'hF;
    localparam int MAX_DIGITS = 4;
endpackage

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer: loadable down-counter whose done flag marks the last cycle of a slot
module seg7_slot_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);
    logic [CW-1:0] cnt;
    // load on slot entry, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign done = cnt == '0;
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed digit scan with blanking gaps and per-digit blanking
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_DIGITS-1:0] digit_blank,
    output logic [1:0]            select,
    output logic [3:0]            anode,
    output logic                  scan_tick,
    output logic                  frame_start
);
    localparam int MAXL = REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW = $clog2(MAXL + 1);
    localparam logic [CW-1:0] SHOW_LD = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
    localparam logic [1:0] LAST = 2'(NUM_DIGITS - 1);
    localparam bit HAS_GAP = BLANK_CYCLES > 0;

    scan_state_t state, state_nx;
    logic [NUM_DIGITS-1:0] blank_q;
    logic [MAX_DIGITS-1:0] blank_ext;
    logic [1:0] select_nx;
    logic [3:0] anode_nx;
    logic [CW-1:0] load_val;
    logic done, slot_end, wrap, load;

    assign blank_ext = MAX_DIGITS'(blank_q);

    seg7_slot_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    // state and registered outputs all move on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SCAN_IDLE;
            select      <= 2'd0;
            anode       <= ANODE_OFF;
            scan_tick   <= 1'b0;
            frame_start <= 1'b0;
            blank_q     <= '0;
        end else begin
            state       <= state_nx;
            select      <= select_nx;
            anode       <= anode_nx;
            scan_tick   <= slot_end;
            frame_start <= slot_end && wrap;
            blank_q     <= digit_blank;
        end
    end

    // next state; with no gap the SHOW slots chain directly
    always_comb begin
        state_nx = state;
        if (!enable) state_nx = SCAN_IDLE;
        else begin
            case (state)
                SCAN_IDLE:  state_nx = HAS_GAP ? SCAN_BLANK : SCAN_SHOW;
                SCAN_BLANK: state_nx = done ? SCAN_SHOW : SCAN_BLANK;
                SCAN_SHOW:  state_nx = done ? (HAS_GAP ? SCAN_BLANK : SCAN_SHOW) : SCAN_SHOW;
                default:    state_nx = SCAN_IDLE;
            endcase
        end
    end

    // next output values and slot timer reload
    always_comb begin
        slot_end  = enable && state == SCAN_SHOW && done;
        wrap      = select == LAST;
        select_nx = (!enable || state == SCAN_IDLE) ? 2'd0 : slot_end ? (wrap ? 2'd0 : select + 2'd1) : select;
        anode_nx  = (state_nx == SCAN_SHOW && !blank_ext[select_nx]) ? ~(4'b0001 << select_nx) : ANODE_OFF;
        load      = !enable || state == SCAN_IDLE || done;
        load_val  = state_nx == SCAN_SHOW ? SHOW_LD : state_nx == SCAN_BLANK ? BLANK_LD : '0;
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: table, directed and randomized checks of the scan controller
module tb_seg7_scan_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic ra = 1'b1, ea = 1'b0;
    logic [1:0] dba = 2'b00;
    logic [1:0] sa;
    logic [3:0] aa;
    logic ta, fa;
    logic rb = 1'b1, eb = 1'b0;
    logic [3:0] dbb = 4'h0;
    logic [1:0] sb;
    logic [3:0] ab;
    logic tkb, fsb;

    int total = 0, bad = 0;
    bit chk_on = 1'b0;

    seg7_scan_ctrl #(.NUM_DIGITS(2), .REFRESH_DIV(4), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .reset(ra), .enable(ea), .digit_blank(dba),
        .select(sa), .anode(aa), .scan_tick(ta), .frame_start(fa)
    );

    seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .reset(rb), .enable(eb), .digit_blank(dbb),
        .select(sb), .anode(ab), .scan_tick(tkb), .frame_start(fsb)
    );

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // k = cycles since the scan started; each slot is a gap followed by the lit digit
    function automatic logic [7:0] model_out(int n, int r, int b, int k, logic [3:0] bq);
        int slot, d, o;
        logic [3:0] one;
        logic tk;
        slot = r + b;
        d = (k / slot) % n;
        o = k % slot;
        one = 4'b0001 << d;
        tk = k > 0 && o == 0;
        return {tk && d == 0, tk, 2'(d), (o < b || bq[d]) ? 4'hF : ~one};
    endfunction

    bit run_a = 1'b0, run_b = 1'b0;
    int ka = 0, kb = 0;
    logic [3:0] bqa = 4'h0, bqb = 4'h0;
    logic [7:0] xa = 8'h0F, xb = 8'h0F;

    always @(posedge clk) begin
        if (ra || !ea) begin
            run_a = 1'b0;
            xa = 8'h0F;
        end else begin
            ka = run_a ? ka + 1 : 0;
            run_a = 1'b1;
            xa = model_out(2, 4, 2, ka, bqa);
        end
        bqa = ra ? 4'h0 : 4'(dba);
        if (rb || !eb) begin
            run_b = 1'b0;
            xb = 8'h0F;
        end else begin
            kb = run_b ? kb + 1 : 0;
            run_b = 1'b1;
            xb = model_out(4, 4, 0, kb, bqb);
        end
        bqb = rb ? 4'h0 : dbb;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_a", {fa, ta, sa, aa}, xa);
            chk("model_b", {fsb, tkb, sb, ab}, xb);
        end
    end

    typedef struct {
        logic r;
        logic e;
        logic [1:0] db;
        logic [3:0] an;
        logic [1:0] sel;
        logic tk;
        logic fs;
    } vec_t;
    vec_t tbl[18];

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int lit, frames, s1, offs, ticks;
        bit found;
        tbl[0]  = '{1'b1, 1'b1, 2'b00, 4'hF, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 2'b00, 4'hF, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 2'b00, 4'hF, 2'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 2'b00, 4'hF, 2'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2'b00, 4'hF, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 2'b00, 4'hE, 2'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 2'b00, 4'hE, 2'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 2'b00, 4'hE, 2'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 2'b00, 4'hE, 2'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 2'b00, 4'hF, 2'd1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 2'b00, 4'hF, 2'd1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 2'b00, 4'hD, 2'd1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 2'b00, 4'hD, 2'd1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 2'b00, 4'hD, 2'd1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 2'b00, 4'hD, 2'd1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 2'b00, 4'hF, 2'd0, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 1'b1, 2'b00, 4'hF, 2'd0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 2'b00, 4'hE, 2'd0, 1'b0, 1'b0};
        step;
        chk_on = 1'b1;
        for (int i = 0; i < 18; i++) begin
            ra = tbl[i].r;
            ea = tbl[i].e;
            dba = tbl[i].db;
            step;
            chk($sformatf("tbl%0d_anode", i), 8'(aa), 8'(tbl[i].an));
            chk($sformatf("tbl%0d_select", i), 8'(sa), 8'(tbl[i].sel));
            chk($sformatf("tbl%0d_tick", i), 8'(ta), 8'(tbl[i].tk));
            chk($sformatf("tbl%0d_frame", i), 8'(fa), 8'(tbl[i].fs));
        end
        dba = 2'b10;
        step;
        step;
        lit = 0;
        frames = 0;
        s1 = 0;
        for (int i = 0; i < 24; i++) begin
            step;
            if (aa != 4'hF) lit++;
            if (fa) frames++;
            if (sa == 2'd1) s1++;
        end
        chk("blank_lit_cycles", 8'(lit), 8'd8);
        chk("blank_frames", 8'(frames), 8'd2);
        chk("blank_sel1_cycles", 8'(s1), 8'd12);
        dba = 2'b00;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step;
            found = sa == 2'd1 && aa == 4'hD;
        end
        chk("wait_show1", 8'(found), 8'd1);
        ea = 1'b0;
        step;
        chk("disable_outs", {fa, ta, sa, aa}, 8'h0F);
        ea = 1'b1;
        step;
        chk("reen_gap1", {fa, ta, sa, aa}, 8'h0F);
        step;
        chk("reen_gap2", {fa, ta, sa, aa}, 8'h0F);
        step;
        chk("reen_show0", {fa, ta, sa, aa}, 8'h0E);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step;
            found = ta;
        end
        chk("wait_tick", 8'(found), 8'd1);
        ra = 1'b1;
        step;
        chk("rst_blank_outs", {fa, ta, sa, aa}, 8'h0F);
        ra = 1'b0;
        step;
        chk("rst_rel_gap1", {fa, ta, sa, aa}, 8'h0F);
        step;
        chk("rst_rel_gap2", {fa, ta, sa, aa}, 8'h0F);
        step;
        chk("rst_rel_show0", {fa, ta, sa, aa}, 8'h0E);
        rb = 1'b0;
        eb = 1'b1;
        offs = 0;
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            step;
            if (ab == 4'hF) offs++;
            if (tkb) ticks++;
        end
        chk("nogap_off_cycles", 8'(offs), 8'd0);
        chk("nogap_ticks", 8'(ticks), 8'd9);
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom_range(0, 199) == 0;
            ea = $urandom_range(0, 49) != 0;
            if ($urandom_range(0, 9) == 0) dba = 2'($urandom);
            rb = $urandom_range(0, 199) == 0;
            eb = $urandom_range(0, 49) != 0;
            if ($urandom_range(0, 9) == 0) dbb = 4'($urandom);
            step;
        end
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
